// File: rtl/earom_ctrl.sv
// rtl/earom_ctrl.sv - ER2055-style 64x8 EAROM emulation behind the Tempest aux-bus strobes
module earom_ctrl #(
  parameter int ADDR_W      = 6,
  parameter int PROG_CYCLES = 16
) (
  input  logic              E3MHZ,
  input  logic              RESET_NOT,
  input  logic [ADDR_W-1:0] EAB,
  input  logic [7:0]        EDB_IN,
  output logic [7:0]        EDB_OUT,
  input  logic              EARWR_NOT,
  input  logic              EARCON_NOT,
  input  logic              EARD_NOT,
  output logic              BUSY
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(PROG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PROG_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERASE,
    ST_WRITE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_lat_q, addr_lat_d;
  logic [7:0]        data_lat_q, data_lat_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              ctrl_clk_q, ctrl_clk_d;
  logic              earwr_q, earwr_d;
  logic              earcon_q, earcon_d;

  // Power-up contents model an erased, non-volatile array; reset never touches it.
  logic [7:0] mem_q [DEPTH] = '{default: 8'hFF};

  logic       wr_edge;
  logic       con_edge;
  logic       trigger;
  logic [1:0] mode;
  logic       mem_we;
  logic [7:0] mem_wdata;

  assign wr_edge  = ~EARWR_NOT & earwr_q;
  assign con_edge = ~EARCON_NOT & earcon_q;
  assign mode     = {EDB_IN[2], EDB_IN[1]};
  // Mode and CS are taken from the write itself, so only the CLK history is kept.
  assign trigger  = con_edge & EDB_IN[0] & ~ctrl_clk_q & EDB_IN[3] & (state_q == ST_IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_lat_d = addr_lat_q;
    data_lat_d = data_lat_q;
    data_out_d = data_out_q;
    ctrl_clk_d = ctrl_clk_q;
    earwr_d    = EARWR_NOT;
    earcon_d   = EARCON_NOT;
    mem_we     = 1'b0;
    mem_wdata  = 8'hFF;

    if (wr_edge && (state_q == ST_IDLE)) begin
      addr_lat_d = EAB;
      data_lat_d = EDB_IN;
    end
    if (con_edge) begin
      ctrl_clk_d = EDB_IN[0];
    end

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          case (mode)
            2'b10: data_out_d = mem_q[addr_lat_d];
            2'b01: begin
              state_d = ST_ERASE;
              cnt_d   = CNT_LOAD;
            end
            2'b00: begin
              state_d = ST_WRITE;
              cnt_d   = CNT_LOAD;
            end
            default: ;
          endcase
        end
      end
      ST_ERASE, ST_WRITE: begin
        if (cnt_q == '0) begin
          // Programming can only clear bits; erase returns the cell to all ones.
          mem_we    = 1'b1;
          mem_wdata = (state_q == ST_ERASE) ? 8'hFF : (mem_q[addr_lat_q] & data_lat_q);
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge E3MHZ or negedge RESET_NOT) begin
    if (!RESET_NOT) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_lat_q <= '0;
      data_lat_q <= '0;
      data_out_q <= '0;
      ctrl_clk_q <= 1'b0;
      earwr_q    <= 1'b1;
      earcon_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_lat_q <= addr_lat_d;
      data_lat_q <= data_lat_d;
      data_out_q <= data_out_d;
      ctrl_clk_q <= ctrl_clk_d;
      earwr_q    <= earwr_d;
      earcon_q   <= earcon_d;
    end
  end

  always_ff @(posedge E3MHZ) begin
    if (mem_we) begin
      mem_q[addr_lat_q] <= mem_wdata;
    end
  end

  assign BUSY    = (state_q != ST_IDLE);
  assign EDB_OUT = EARD_NOT ? 8'h00 : data_out_q;

endmodule

// File: tb/tb_earom_ctrl.sv
// tb/tb_earom_ctrl.sv - randomized bench for earom_ctrl against a transaction-level model
module tb_earom_ctrl;

  localparam int P = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] eab;
  logic [7:0] edb_in;
  logic [7:0] edb_out;
  logic       earwr_n;
  logic       earcon_n;
  logic       eard_n;
  logic       busy;

  always #5 clk = ~clk;

  earom_ctrl #(.ADDR_W(6), .PROG_CYCLES(P)) dut (
    .E3MHZ      (clk),
    .RESET_NOT  (rst_n),
    .EAB        (eab),
    .EDB_IN     (edb_in),
    .EDB_OUT    (edb_out),
    .EARWR_NOT  (earwr_n),
    .EARCON_NOT (earcon_n),
    .EARD_NOT   (eard_n),
    .BUSY       (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int busy_total = 0;

  always @(negedge clk) if (busy === 1'b1) busy_total = busy_total + 1;

  // Reference model: array contents, latches, last CLK, read data, pending op (0 none, 1 erase, 2 write)
  logic [7:0] m_mem [64];
  logic [5:0] m_addr;
  logic [7:0] m_data;
  logic [7:0] m_dout;
  logic       m_clk;
  int         m_op;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = '0; m_data = '0; m_dout = '0; m_clk = 1'b0; m_op = 0;
  endtask

  task automatic model_latch(input logic [5:0] a, input logic [7:0] d);
    if (m_op == 0) begin
      m_addr = a;
      m_data = d;
    end
  endtask

  task automatic model_ctrl(input logic [3:0] v);
    if (v[0] && !m_clk && v[3] && m_op == 0) begin
      if (v[2] && !v[1]) m_dout = m_mem[m_addr];
      else if (!v[2] && v[1]) m_op = 1;
      else if (!v[2] && !v[1]) m_op = 2;
    end
    m_clk = v[0];
  endtask

  task automatic model_complete();
    if (m_op == 1) m_mem[m_addr] = 8'hFF;
    else if (m_op == 2) m_mem[m_addr] = m_mem[m_addr] & m_data;
    m_op = 0;
  endtask

  task automatic pulse_wr(input logic [5:0] a, input logic [7:0] d);
    eab = a; edb_in = d; earwr_n = 1'b0;
    @(posedge clk); #1 earwr_n = 1'b1;
    model_latch(a, d);
    @(posedge clk); #1;
  endtask

  task automatic pulse_con(input logic [3:0] v);
    edb_in = {4'h0, v}; earcon_n = 1'b0;
    @(posedge clk); #1 earcon_n = 1'b1;
    model_ctrl(v);
    @(posedge clk); #1;
  endtask

  task automatic pulse_both(input logic [5:0] a, input logic [3:0] v);
    eab = a; edb_in = {4'h0, v}; earwr_n = 1'b0; earcon_n = 1'b0;
    @(posedge clk); #1 earwr_n = 1'b1; earcon_n = 1'b1;
    model_latch(a, {4'h0, v});
    model_ctrl(v);
    @(posedge clk); #1;
  endtask

  task automatic read_data_out(input string tag);
    eard_n = 1'b0;
    #1 check({tag, "_dout"}, edb_out, m_dout);
    eard_n = 1'b1;
    #1 check({tag, "_gated"}, edb_out, 8'h00);
  endtask

  task automatic wait_done(input string tag, input int snap);
    for (int i = 0; i < 4 * P && busy === 1'b1; i++) @(negedge clk);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_busylen"}, busy_total - snap, P);
    model_complete();
    @(posedge clk); #1;
  endtask

  task automatic do_read(input string tag, input logic [5:0] a);
    pulse_wr(a, 8'($urandom));
    pulse_con(4'hC);
    pulse_con(4'hD);
    read_data_out(tag);
  endtask

  task automatic do_prog(input string tag, input logic [5:0] a, input logic [7:0] d, input logic [3:0] v);
    int snap;
    pulse_wr(a, d);
    pulse_con(v & 4'hE);
    snap = busy_total;
    pulse_con(v | 4'h1);
    check({tag, "_busyrise"}, busy, 1'b1);
    wait_done(tag, snap);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int snap;
    logic [3:0] v;
    logic [5:0] a;
    logic [7:0] d;

    for (int i = 0; i < 64; i++) m_mem[i] = 8'hFF;
    model_reset();
    rst_n = 1'b0; eab = '0; edb_in = '0;
    earwr_n = 1'b1; earcon_n = 1'b1; eard_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("rst_busy", busy, 1'b0);
    read_data_out("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    do_read("rd_fresh", 6'h05);
    do_prog("erase5", 6'h05, 8'hA5, 4'hB);
    do_prog("write5", 6'h05, 8'hA5, 4'h9);
    do_read("rd_a5", 6'h05);

    // Second write while a stray latch and CLK edge arrive mid-operation
    pulse_wr(6'h05, 8'h3C);
    pulse_con(4'h8);
    snap = busy_total;
    pulse_con(4'h9);
    check("w2_busyrise", busy, 1'b1);
    pulse_wr(6'h06, 8'h00);
    pulse_con(4'h8);
    pulse_con(4'h9);
    wait_done("w2", snap);
    do_read("rd_and", 6'h05);
    do_read("rd_untouched6", 6'h06);

    // Reset five cycles into a write aborts it
    pulse_wr(6'h07, 8'h00);
    pulse_con(4'h8);
    pulse_con(4'h9);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("abort_busy", busy, 1'b0);
    model_reset();
    read_data_out("abort_rst");
    @(negedge clk) rst_n = 1'b1;
    snap = busy_total;
    repeat (P + 2) @(negedge clk);
    check("abort_nobusy", busy_total - snap, 0);
    @(posedge clk); #1;
    do_read("rd_abort7", 6'h07);

    // CLK held high: long strobe and a rewrite act only once
    pulse_wr(6'h05, 8'h11);
    pulse_con(4'hC);
    edb_in = 8'h0D; earcon_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 earcon_n = 1'b1;
    model_ctrl(4'hD);
    @(posedge clk); #1;
    read_data_out("hold_rd");
    pulse_wr(6'h06, 8'h00);
    pulse_con(4'hD);
    read_data_out("hold_noretrig");
    pulse_con(4'hB);
    check("hold_noerase", busy, 1'b0);

    // Simultaneous latch and control edge uses the new address
    pulse_con(4'hC);
    pulse_both(6'h05, 4'hD);
    read_data_out("both_rd");

    for (int it = 0; it < 40; it++) begin
      a = 6'($urandom_range(0, 7));
      d = 8'($urandom);
      v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) v[3] = 1'b1;
      pulse_con(v & 4'hE);
      snap = busy_total;
      if ($urandom_range(0, 3) == 0) begin
        pulse_both(a, v | 4'h1);
      end else begin
        pulse_wr(a, d);
        snap = busy_total;
        pulse_con(v | 4'h1);
      end
      if (m_op != 0) begin
        check("rnd_busyrise", busy, 1'b1);
        wait_done("rnd", snap);
      end else begin
        check("rnd_nobusy", busy, 1'b0);
      end
      read_data_out("rnd");
      if (it % 4 == 3) do_read("rnd_rd", 6'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/earom_ctrl.md
# earom_ctrl

High-score EAROM controller for the Tempest auxiliary bus. It consumes the active-low EAROM strobes that the aux-board address decoder produces: EARWR_NOT, EARCON_NOT and EARD_NOT. It latches the address and data, and emulates an ER2055-style 64x8 electrically-alterable ROM with timed erase and write cycles. EDB_OUT feeds the aux-board read mux alongside the POKEY and math-box data.

## Interface
Parameters:
- ADDR_W, 6, EAROM address width (64 locations)
- PROG_CYCLES, 16, E3MHZ cycles an erase or write occupies (must be >= 2)

Ports:
- E3MHZ  in  1  system clock; every register updates on its rising edge
- RESET_NOT  in  1  asynchronous active-low reset
- EAB  in  ADDR_W  CPU address bits; sampled on an EARWR_NOT write
- EDB_IN  in  8  CPU write data
- EDB_OUT  out  8  EAROM read data; 8'h00 when EARD_NOT is high
- EARWR_NOT  in  1  active-low strobe: latch address and data
- EARCON_NOT  in  1  active-low strobe: write the control register
- EARD_NOT  in  1  active-low strobe: CPU read of the EAROM data
- BUSY  out  1  high while an erase or write is in progress

## Operation
- Strobes are synchronous to E3MHZ and may stay low for several cycles. Each strobe acts once, on its first low cycle: the falling edge is detected against a registered copy of the strobe.
- EARWR_NOT edge:
  - addr_lat <= EAB; data_lat <= EDB_IN.
  - Ignored while BUSY = 1.
- EARCON_NOT edge:
  - ctrl <= EDB_IN[3:0], with bit0 = CLK, bit1 = C2, bit2 = C1, bit3 = CS.
  - The control register updates even while BUSY.
- Trigger: a control write where new CLK = 1, previous CLK = 0, new CS = 1, and BUSY = 0. When BUSY = 1 the write only updates ctrl; no operation starts.
- Mode {C1,C2} at the trigger:
  - 2'b10 READ: data_out <= mem[addr_lat] in the same edge that registers ctrl. BUSY is not asserted.
  - 2'b01 ERASE: BUSY <= 1 and the counter loads PROG_CYCLES-1. When the counter reaches 0, mem[addr_lat] <= 8'hFF and BUSY <= 0.
  - 2'b00 WRITE: same timing as ERASE. At completion, mem[addr_lat] <= mem[addr_lat] & data_lat, so programming can only clear bits.
  - 2'b11: no-op.
- Array: 2^ADDR_W x 8. Initialised to 8'hFF at configuration. Reset does not touch it (non-volatile behaviour).
- EDB_OUT = EARD_NOT ? 8'h00 : data_out. This is combinational gating of the registered data_out.
- Simultaneous EARWR_NOT and EARCON_NOT edges: both are processed. An operation triggered on that edge uses the newly latched addr and data.

## Timing
- Reset (RESET_NOT low, asynchronous):
  - addr_lat, data_lat, ctrl, data_out, counter <= 0; BUSY <= 0.
  - Registered strobe copies <= 1, so a strobe held low through the release of reset counts as an edge on the first clock after release.
- Reset mid-erase or mid-write aborts the operation; the array is left unchanged.
- READ latency: data_out is valid the cycle after the EARCON_NOT falling edge is sampled.
- ERASE/WRITE:
  - BUSY rises one cycle after the trigger edge and stays high for exactly PROG_CYCLES cycles.
  - The array update and the BUSY fall occur on the same edge.
  - A READ of the same address issued after BUSY falls returns the new value.
- Counter wrap: the counter never decrements below 0 and is idle at 0.
- CLK held at 1 across repeated control writes does not retrigger; CLK must return to 0 and rise again.

## Test plan
- Reset, then READ of address 0x05: control writes 0x0C then 0x0D -> EDB_OUT = 8'hFF while EARD_NOT is low, 8'h00 while EARD_NOT is high.
- Latch 0x05/8'hA5, control 0x0A then 0x0B (ERASE), wait for BUSY to fall, control 0x08 then 0x09 (WRITE), wait, then READ -> BUSY high exactly 16 cycles each time; read returns 8'hA5.
- Second WRITE of 8'h3C to address 0x05 without an erase -> read returns 8'h24, the AND of the two values.
- During a WRITE, strobe EARWR_NOT with address 0x06 / 8'h00 and issue another CLK edge -> both are ignored; address 0x05 alone changes and BUSY timing is unaffected.
- Assert RESET_NOT low 5 cycles into a WRITE of 8'h00 to address 0x07 -> BUSY = 0 immediately; a later READ of 0x07 returns 8'hFF.
- Hold EARCON_NOT low for 4 cycles with 0x0D, then rewrite 0x0D without dropping CLK -> a single READ action; no retrigger.
